// File: rtl/puf_eval_sequencer.sv
// Repeats one PUF datapath evaluation reps times, majority-votes each response bit and flags split votes.
// Define PUF_SEQ_SETTLE_EN to insert SETTLE_CYCLES idle cycles between consecutive evaluations.
module puf_eval_sequencer #(
  parameter int CH_WIDTH       = 128,
  parameter int RSP_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           num_evals,
  input  logic [CH_WIDTH-1:0]  challenge_in,
  input  logic [15:0]          op_a_in,
  input  logic [15:0]          op_b_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [RSP_WIDTH-1:0] response_out,
  output logic [RSP_WIDTH-1:0] unstable_mask,
  output logic                 puf_trigger,
  output logic [CH_WIDTH-1:0]  puf_challenge,
  output logic [15:0]          puf_op_a,
  output logic [15:0]          puf_op_b,
  input  logic                 puf_done,
  input  logic [RSP_WIDTH-1:0] puf_response,
  output logic [2:0]           dbgState
);

  // Handshakes: start is taken only in IDLE with busy=0 (never queued); each evaluation is one
  // puf_trigger pulse, and the answer is the first puf_done=1 seen after puf_done was sampled low.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    ACCUM     = 3'd4,
`ifdef PUF_SEQ_SETTLE_EN
    SETTLE    = 3'd5,
`endif
    VOTE      = 3'd6,
    FINISH    = 3'd7
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [7:0]             reps;
  logic [7:0]             evalCnt;
  logic [7:0]             voteCnt [RSP_WIDTH];
  logic [RSP_WIDTH-1:0]   capReg;
  logic [TO_W-1:0]        timeoutCnt;

`ifdef PUF_SEQ_SETTLE_EN
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
  logic [ST_W-1:0]        settleCnt;
`else
  logic unusedSettle;
  assign unusedSettle = (SETTLE_CYCLES != 0);
`endif

  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      response_out  <= '0;
      unstable_mask <= '0;
      puf_trigger   <= 1'b0;
      puf_challenge <= '0;
      puf_op_a      <= '0;
      puf_op_b      <= '0;
      reps          <= '0;
      evalCnt       <= '0;
      capReg        <= '0;
      timeoutCnt    <= '0;
      for (int i = 0; i < RSP_WIDTH; i++) voteCnt[i] <= '0;
`ifdef PUF_SEQ_SETTLE_EN
      settleCnt     <= '0;
`endif
    end else begin
      puf_trigger <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !busy) begin
            puf_challenge <= challenge_in;
            puf_op_a      <= op_a_in;
            puf_op_b      <= op_op_b_sel(op_b_in);
            reps          <= (num_evals == 8'd0) ? 8'd1 : num_evals;
            evalCnt       <= '0;
            for (int i = 0; i < RSP_WIDTH; i++) voteCnt[i] <= '0;
            err_timeout   <= 1'b0;
            response_out  <= '0;
            unstable_mask <= '0;
            busy          <= 1'b1;
            puf_trigger   <= 1'b1;
            state         <= TRIG;
          end
        end
        TRIG: begin
          timeoutCnt <= '0;
          state      <= WAIT_LOW;
        end
        WAIT_LOW, WAIT_HIGH: begin
          // A valid answer in WAIT_HIGH wins over a timeout expiring in the same cycle.
          if (state == WAIT_HIGH && puf_done) begin
            capReg <= puf_response;
            state  <= ACCUM;
          end else if (timeoutCnt == TO_LAST) begin
            err_timeout   <= 1'b1;
            response_out  <= '0;
            unstable_mask <= '1;
            done          <= 1'b1;
            state         <= FINISH;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
            if (state == WAIT_LOW && !puf_done) state <= WAIT_HIGH;
          end
        end
        ACCUM: begin
          for (int i = 0; i < RSP_WIDTH; i++) voteCnt[i] <= voteCnt[i] + {7'd0, capReg[i]};
          evalCnt <= evalCnt + 8'd1;
          if (evalCnt + 8'd1 == reps) begin
            state <= VOTE;
          end else begin
`ifdef PUF_SEQ_SETTLE_EN
            settleCnt <= '0;
            state     <= SETTLE;
`else
            puf_trigger <= 1'b1;
            state       <= TRIG;
`endif
          end
        end
`ifdef PUF_SEQ_SETTLE_EN
        SETTLE: begin
          if (settleCnt == ST_LAST) begin
            puf_trigger <= 1'b1;
            state       <= TRIG;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end
`endif
        VOTE: begin
          // 9-bit compare so 2*cnt cannot wrap; an exact tie votes 0.
          for (int i = 0; i < RSP_WIDTH; i++) begin
            response_out[i]  <= ({voteCnt[i], 1'b0} > {1'b0, reps});
            unstable_mask[i] <= (voteCnt[i] != 8'd0) && (voteCnt[i] != reps);
          end
          done  <= 1'b1;
          state <= FINISH;
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [15:0] op_op_b_sel(input logic [15:0] v);
    return v;
  endfunction

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed + randomized bench for puf_eval_sequencer with a behavioural PUF datapath responder
// and a vote/latency reference model computed from the per-evaluation response and latency lists.
module tb_puf_eval_sequencer;

  localparam int TIMEOUT = 8;
`ifdef PUF_SEQ_SETTLE_EN
  localparam int SETTLE = 4;
`else
  localparam int SETTLE = 0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [7:0]   num_evals;
  logic [127:0] challenge_in;
  logic [15:0]  op_a_in, op_b_in;
  logic         busy, done, err_timeout;
  logic [15:0]  response_out, unstable_mask;
  logic         puf_trigger;
  logic [127:0] puf_challenge;
  logic [15:0]  puf_op_a, puf_op_b;
  logic         puf_done;
  logic [15:0]  puf_response;
  logic [2:0]   dbgState;

  puf_eval_sequencer #(
    .CH_WIDTH(128), .RSP_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_evals(num_evals),
    .challenge_in(challenge_in), .op_a_in(op_a_in), .op_b_in(op_b_in),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .response_out(response_out), .unstable_mask(unstable_mask),
    .puf_trigger(puf_trigger), .puf_challenge(puf_challenge),
    .puf_op_a(puf_op_a), .puf_op_b(puf_op_b),
    .puf_done(puf_done), .puf_response(puf_response), .dbgState(dbgState)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int passed = 0, failed = 0, total = 0;
  logic [15:0] rsp_q[$];
  logic [15:0] run_rsp[$];
  int lat_q[$];
  int run_lat[$];
  int trig_cyc_q[$];
  int hold_next = 0;
  bit stuck_low = 0;
  bit pulse_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // behavioural datapath: answers each trigger after cur_k cycles, optionally holding an old done level
  int dp_c, cur_k, cur_h;
  bit dp_active;
  logic [15:0] cur_rsp;
  initial begin
    puf_done = 1'b0;
    puf_response = '0;
    dp_active = 1'b0;
    forever begin
      @(negedge clk);
      if (puf_trigger === 1'b1) begin
        trig_cyc_q.push_back(cyc);
        puf_response = 16'($urandom);
        if (stuck_low) begin
          dp_active = 1'b0;
          puf_done = 1'b0;
        end else begin
          cur_rsp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'($urandom);
          cur_k = (lat_q.size() > 0) ? lat_q.pop_front() : 2;
          cur_h = hold_next;
          hold_next = 0;
          dp_c = 0;
          dp_active = 1'b1;
          if (cur_h == 0) puf_done = 1'b0;
        end
      end else if (dp_active) begin
        dp_c++;
        if (dp_c == cur_h) puf_done = 1'b0;
        if (dp_c == cur_k) begin
          puf_done = 1'b1;
          puf_response = cur_rsp;
          if (!pulse_mode) dp_active = 1'b0;
        end else if (dp_c > cur_k) begin
          puf_done = 1'b0;
          puf_response = 16'($urandom);
          dp_active = 1'b0;
        end
      end
    end
  end

  // driver + model: one full run using run_rsp/run_lat as the per-evaluation plan
  task automatic do_run(input logic [7:0] n, input int hold, input bit stuck, input bit poke);
    int reps, exp_lat, cnt, budget, acc;
    bit got;
    logic [15:0] exp_rsp, exp_mask, op_a, op_b;
    logic [127:0] chal;
    reps = (n == 8'd0) ? 1 : int'(n);
    exp_rsp = '0;
    exp_mask = '0;
    for (int b = 0; b < 16; b++) begin
      cnt = 0;
      foreach (run_rsp[j]) cnt += int'(run_rsp[j][b]);
      exp_rsp[b] = (2 * cnt > reps);
      exp_mask[b] = (cnt != 0) && (cnt != reps);
    end
    exp_lat = 2 + SETTLE * (reps - 1);
    foreach (run_lat[j]) exp_lat += run_lat[j] + 2;
    if (stuck) begin
      exp_rsp = '0;
      exp_mask = '1;
      exp_lat = 2 + TIMEOUT;
    end
    rsp_q = run_rsp;
    lat_q = run_lat;
    trig_cyc_q.delete();
    hold_next = hold;
    stuck_low = stuck;
    chal = {$urandom, $urandom, $urandom, $urandom};
    op_a = 16'($urandom);
    op_b = 16'($urandom);

    @(negedge clk);
    start = 1'b1;
    num_evals = n;
    challenge_in = chal;
    op_a_in = op_a;
    op_b_in = op_b;
    acc = cyc;
    @(negedge clk);
    start = 1'b0;
    challenge_in = ~chal;
    op_a_in = ~op_a;
    op_b_in = ~op_b;
    check("busy_after_accept", 32'(busy), 1);

    budget = 6000;
    got = 1'b0;
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      num_evals = 8'd9;
      @(negedge clk);
      start = 1'b0;
      budget -= 2;
    end
    while (!got && budget > 0) begin
      @(negedge clk);
      budget--;
      if (done === 1'b1) got = 1'b1;
    end
    check("done_seen", 32'(got), 1);
    check("latency", 32'(cyc - acc), 32'(exp_lat));
    check("err_timeout", 32'(err_timeout), 32'(stuck));
    check("response", 32'(response_out), 32'(exp_rsp));
    check("unstable", 32'(unstable_mask), 32'(exp_mask));
    check("trig_count", 32'(trig_cyc_q.size()), stuck ? 32'd1 : 32'(reps));
    check("challenge_held", 32'(puf_challenge === chal), 1);
    check("ops_held", {puf_op_a, puf_op_b}, {op_a, op_b});
    if (!stuck)
      for (int i = 1; i < trig_cyc_q.size() && i < 8 && i < run_lat.size(); i++)
        check("trig_gap", 32'(trig_cyc_q[i] - trig_cyc_q[i-1]), 32'(run_lat[i-1] + 2 + SETTLE));
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("busy_released", 32'(busy), 0);
  endtask

  initial begin
    logic [15:0] base;
    int n;
    bit got;
    reset = 1'b1;
    start = 1'b0;
    num_evals = '0;
    challenge_in = '0;
    op_a_in = '0;
    op_b_in = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {28'd0, busy, done, err_timeout, puf_trigger}, 0);
    check("reset_resp", 32'(response_out), 0);
    check("reset_mask", 32'(unstable_mask), 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(dbgState), 0);

    // basic single evaluation
    run_rsp = '{16'hA5C3};
    run_lat = '{2};
    do_run(8'd1, 0, 1'b0, 1'b0);

    // majority of three
    run_rsp = '{16'hFFFF, 16'h0000, 16'hFFFF};
    run_lat = '{2, 3, 4};
    do_run(8'd3, 0, 1'b0, 1'b0);

    // zero treated as one
    run_rsp = '{16'h3C5A};
    run_lat = '{3};
    do_run(8'd0, 0, 1'b0, 1'b0);

    // tie votes zero, split bit flagged; done left high afterwards
    run_rsp = '{16'h0001, 16'h0000};
    run_lat = '{2, 5};
    do_run(8'd2, 0, 1'b0, 1'b0);

    // done level held over from the previous run must not be accepted
    run_rsp = '{16'h8421, 16'h8421};
    run_lat = '{6, 2};
    do_run(8'd2, 3, 1'b0, 1'b0);

    // start while busy is ignored
    run_rsp = '{16'h1111, 16'h1010};
    run_lat = '{3, 3};
    do_run(8'd2, 0, 1'b0, 1'b1);

    // datapath never answers
    run_rsp = '{16'h0};
    run_lat = '{2};
    do_run(8'd1, 0, 1'b1, 1'b0);
    stuck_low = 1'b0;

    // reset in WAIT_HIGH: accept at A, WAIT_HIGH spans A+3..A+6 with latency 6
    rsp_q.delete();
    lat_q.delete();
    rsp_q.push_back(16'h1234);
    lat_q.push_back(6);
    @(negedge clk);
    start = 1'b1;
    num_evals = 8'd1;
    challenge_in = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
    op_a_in = 16'h00F1;
    op_b_in = 16'h00F2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ctrl", {28'd0, busy, done, err_timeout, puf_trigger}, 0);
    check("midrst_resp", {response_out, unstable_mask}, 0);
    check("midrst_chal", 32'(puf_challenge === 128'd0), 1);
    check("midrst_ops", {puf_op_a, puf_op_b}, 0);
    check("midrst_state", 32'(dbgState), 0);
    repeat (8) @(negedge clk);
    rsp_q.delete();
    lat_q.delete();
    run_rsp = '{16'hBEEF};
    run_lat = '{4};
    do_run(8'd1, 0, 1'b0, 1'b0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 7);
      base = 16'($urandom);
      pulse_mode = 1'($urandom_range(0, 1));
      run_rsp.delete();
      run_lat.delete();
      for (int j = 0; j < n; j++) begin
        run_rsp.push_back(base ^ 16'($urandom & $urandom & $urandom));
        run_lat.push_back($urandom_range(2, 6));
      end
      do_run(8'(n), 0, 1'b0, 1'b0);
    end

    // 255 unanimous ones: counters reach 255 without wrapping
    pulse_mode = 1'b0;
    run_rsp.delete();
    run_lat.delete();
    for (int j = 0; j < 255; j++) begin
      run_rsp.push_back(16'hFFFF);
      run_lat.push_back($urandom_range(2, 3));
    end
    do_run(8'd255, 0, 1'b0, 1'b0);

    got = (total > 0);
    if (!got) $display("no checks executed");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
